// File: rtl/sram_dual_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (A and B).
interface sram_dual_arbiter_if;
    logic        req;
    logic        we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    // Requester drives the request fields and receives completion/data.
    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    // Arbiter samples the request fields and returns completion/data.
    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/sram_dual_arbiter.sv
// Round-robin arbiter sharing two asynchronous SRAM banks between requesters A and B.
// One physical access at a time: IDLE -> SETUP -> ACCESS (N cycles) -> DONE -> IDLE.
module sram_dual_arbiter #(
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_dual_arbiter_if.slave    a_if,
    sram_dual_arbiter_if.slave    b_if,
    output logic [17:0]           ram_addr1,
    output logic [17:0]           ram_addr2,
    inout  wire  [15:0]           ram_data1,
    inout  wire  [15:0]           ram_data2,
    output logic                  ram1EN,
    output logic                  ram1OE,
    output logic                  ram1WE,
    output logic                  ram2EN,
    output logic                  ram2OE,
    output logic                  ram2WE,
    output logic                  busy,
    output logic                  last_b
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned WR_N  = (WR_CYCLES < 1) ? 32'd1 : 32'(WR_CYCLES);
    localparam int unsigned RD_N  = (RD_CYCLES < 1) ? 32'd1 : 32'(RD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               gnt_b_q;
    logic               we_q;
    logic               bank_q;
    logic [15:0]        wdata_q;
    logic               last_b_q;
    logic               busy_q;
    logic               a_ack_q;
    logic               b_ack_q;
    logic [15:0]        a_rdata_q;
    logic [15:0]        b_rdata_q;
    logic [17:0]        ram_addr1_q;
    logic [17:0]        ram_addr2_q;
    logic               ram1_en_q;
    logic               ram1_oe_q;
    logic               ram1_we_q;
    logic               ram2_en_q;
    logic               ram2_oe_q;
    logic               ram2_we_q;
    logic               drv1_q;
    logic               drv2_q;

    logic               grant_b_c;
    logic               sel_we_c;
    logic [16:0]        sel_addr_c;
    logic [15:0]        sel_wdata_c;
    logic               sel_bank_c;
    logic [17:0]        phys_addr_c;

    // Round robin: a lone request wins; on a tie the side not granted last wins.
    assign grant_b_c   = b_if.req && (!a_if.req || !last_b_q);
    assign sel_we_c    = grant_b_c ? b_if.we    : a_if.we;
    assign sel_addr_c  = grant_b_c ? b_if.addr  : a_if.addr;
    assign sel_wdata_c = grant_b_c ? b_if.wdata : a_if.wdata;
    assign sel_bank_c  = sel_addr_c[16];
    assign phys_addr_c = {2'b00, sel_addr_c[15:0]};

    // Sequencer: grant, strobe timing, read capture and completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gnt_b_q     <= 1'b0;
            we_q        <= 1'b0;
            bank_q      <= 1'b0;
            wdata_q     <= '0;
            last_b_q    <= 1'b1;
            busy_q      <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            ram_addr1_q <= '0;
            ram_addr2_q <= '0;
            ram1_en_q   <= 1'b1;
            ram1_oe_q   <= 1'b1;
            ram1_we_q   <= 1'b1;
            ram2_en_q   <= 1'b1;
            ram2_oe_q   <= 1'b1;
            ram2_we_q   <= 1'b1;
            drv1_q      <= 1'b0;
            drv2_q      <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_if.req || b_if.req) begin
                        state_q     <= S_SETUP;
                        busy_q      <= 1'b1;
                        gnt_b_q     <= grant_b_c;
                        last_b_q    <= grant_b_c;
                        we_q        <= sel_we_c;
                        bank_q      <= sel_bank_c;
                        wdata_q     <= sel_wdata_c;
                        ram_addr1_q <= sel_bank_c ? 18'd0 : phys_addr_c;
                        ram_addr2_q <= sel_bank_c ? phys_addr_c : 18'd0;
                        ram1_en_q   <= sel_bank_c;
                        ram2_en_q   <= !sel_bank_c;
                        ram1_oe_q   <= sel_bank_c || sel_we_c;
                        ram2_oe_q   <= !sel_bank_c || sel_we_c;
                        drv1_q      <= sel_we_c && !sel_bank_c;
                        drv2_q      <= sel_we_c && sel_bank_c;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    cnt_q     <= we_q ? CNT_W'(WR_N - 1) : CNT_W'(RD_N - 1);
                    ram1_we_q <= !(we_q && !bank_q);
                    ram2_we_q <= !(we_q && bank_q);
                end
                S_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_DONE;
                        ram1_we_q <= 1'b1;
                        ram2_we_q <= 1'b1;
                        ram1_oe_q <= 1'b1;
                        ram2_oe_q <= 1'b1;
                        a_ack_q   <= !gnt_b_q;
                        b_ack_q   <= gnt_b_q;
                        if (!we_q) begin
                            if (gnt_b_q) begin
                                b_rdata_q <= bank_q ? ram_data2 : ram_data1;
                            end else begin
                                a_rdata_q <= bank_q ? ram_data2 : ram_data1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    ram1_en_q   <= 1'b1;
                    ram2_en_q   <= 1'b1;
                    drv1_q      <= 1'b0;
                    drv2_q      <= 1'b0;
                    ram_addr1_q <= '0;
                    ram_addr2_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write data is driven only on the selected bank, only during write cycles.
    assign ram_data1 = drv1_q ? wdata_q : 16'hzzzz;
    assign ram_data2 = drv2_q ? wdata_q : 16'hzzzz;

    assign ram_addr1  = ram_addr1_q;
    assign ram_addr2  = ram_addr2_q;
    assign ram1EN     = ram1_en_q;
    assign ram1OE     = ram1_oe_q;
    assign ram1WE     = ram1_we_q;
    assign ram2EN     = ram2_en_q;
    assign ram2OE     = ram2_oe_q;
    assign ram2WE     = ram2_we_q;
    assign busy       = busy_q;
    assign last_b     = last_b_q;
    assign a_if.ack   = a_ack_q;
    assign a_if.rdata = a_rdata_q;
    assign b_if.ack   = b_ack_q;
    assign b_if.rdata = b_rdata_q;

endmodule

// File: tb/tb_sram_dual_arbiter.sv
// Directed bench for sram_dual_arbiter with a small behavioural SRAM on each bank.
module tb_sram_dual_arbiter;

    logic        clk;
    logic        rst;
    wire  [17:0] ram_addr1;
    wire  [17:0] ram_addr2;
    wire  [15:0] ram_data1;
    wire  [15:0] ram_data2;
    wire         ram1EN, ram1OE, ram1WE;
    wire         ram2EN, ram2OE, ram2WE;
    wire         busy;
    wire         last_b;

    sram_dual_arbiter_if a_if ();
    sram_dual_arbiter_if b_if ();

    sram_dual_arbiter #(
        .WR_CYCLES (2),
        .RD_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_if      (a_if),
        .b_if      (b_if),
        .ram_addr1 (ram_addr1),
        .ram_addr2 (ram_addr2),
        .ram_data1 (ram_data1),
        .ram_data2 (ram_data2),
        .ram1EN    (ram1EN),
        .ram1OE    (ram1OE),
        .ram1WE    (ram1WE),
        .ram2EN    (ram2EN),
        .ram2OE    (ram2OE),
        .ram2WE    (ram2WE),
        .busy      (busy),
        .last_b    (last_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAMs: 64 words each, read when EN and OE low, write while WE low.
    logic [15:0] mem1 [0:63];
    logic [15:0] mem2 [0:63];

    assign ram_data1 = (!ram1EN && !ram1OE) ? mem1[ram_addr1[5:0]] : 16'hzzzz;
    assign ram_data2 = (!ram2EN && !ram2OE) ? mem2[ram_addr2[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst) begin
            mem2[5] <= 16'hBEEF;
        end else begin
            if (!ram1EN && !ram1WE) mem1[ram_addr1[5:0]] <= ram_data1;
            if (!ram2EN && !ram2WE) mem2[ram_addr2[5:0]] <= ram_data2;
        end
    end

    // Strobe monitor: low-cycle counts, protocol violations, ack pulses.
    int          we1_lo, we2_lo, oe1_lo, oe2_lo, en1_lo, en2_lo;
    int          viol, a_acks, b_acks;
    logic        prev_we1_lo, prev_we2_lo, prev_a_ack, prev_b_ack;
    logic [17:0] prev_addr1, prev_addr2;

    initial begin
        we1_lo = 0; we2_lo = 0; oe1_lo = 0; oe2_lo = 0; en1_lo = 0; en2_lo = 0;
        viol = 0; a_acks = 0; b_acks = 0;
        prev_we1_lo = 1'b0; prev_we2_lo = 1'b0; prev_a_ack = 1'b0; prev_b_ack = 1'b0;
        prev_addr1 = '0; prev_addr2 = '0;
    end

    always @(negedge clk) begin
        if (!ram1WE) we1_lo++;
        if (!ram2WE) we2_lo++;
        if (!ram1OE) oe1_lo++;
        if (!ram2OE) oe2_lo++;
        if (!ram1EN) en1_lo++;
        if (!ram2EN) en2_lo++;
        if (a_if.ack) a_acks++;
        if (b_if.ack) b_acks++;
        if ((!ram1WE && !ram1OE) || (!ram2WE && !ram2OE)) viol++;
        if (!ram1EN && !ram2EN) viol++;
        if (a_if.ack && b_if.ack) viol++;
        if ((a_if.ack && prev_a_ack) || (b_if.ack && prev_b_ack)) viol++;
        if (!ram1WE && prev_we1_lo && (ram_addr1 != prev_addr1)) viol++;
        if (!ram2WE && prev_we2_lo && (ram_addr2 != prev_addr2)) viol++;
        prev_we1_lo = !ram1WE;
        prev_we2_lo = !ram2WE;
        prev_a_ack  = a_if.ack;
        prev_b_ack  = b_if.ack;
        prev_addr1  = ram_addr1;
        prev_addr2  = ram_addr2;
    end

    task automatic mon_clear();
        we1_lo = 0; we2_lo = 0; oe1_lo = 0; oe2_lo = 0; en1_lo = 0; en2_lo = 0;
        viol = 0; a_acks = 0; b_acks = 0;
    endtask

    int n_vec;
    int n_err;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Values captured in the cycle the ack is seen.
    logic [17:0] snap_addr1, snap_addr2;
    logic [15:0] snap_data1, snap_rdata;

    // One transaction from one side; returns edges from request to visible ack.
    task automatic run_xact(input bit side, input bit we, input logic [16:0] addr,
                            input logic [15:0] wd, input bit mid_chg, output int edges);
        logic ack;
        edges = 0;
        ack   = 1'b0;
        if (!side) begin
            a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
        end else begin
            b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (mid_chg && edges == 1) begin
                a_if.addr  = 17'h1000A;
                a_if.wdata = 16'h0BAD;
            end
            ack = side ? b_if.ack : a_if.ack;
            if (ack) break;
        end
        if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
        snap_addr1 = ram_addr1;
        snap_addr2 = ram_addr2;
        snap_data1 = ram_data1;
        snap_rdata = side ? b_if.rdata : a_if.rdata;
        if (!side) a_if.req = 1'b0; else b_if.req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    int edges;
    int n_ack;
    int ack_side [4];
    int ack_cyc  [4];
    int cyc;

    initial begin
        n_vec = 0;
        n_err = 0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        rst = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_strobes", 32'({ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}), 32'h3F);
        chk("rst_acks",    32'({a_if.ack, b_if.ack}), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_last_b",  32'(last_b), 32'd1);
        chk("rst_addr",    32'({ram_addr1, ram_addr2} != 36'd0), 32'd0);
        chk("rst_rdata",   32'({a_if.rdata, b_if.rdata}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // A writes 0x1234 to ram1 word 5.
        mon_clear();
        run_xact(1'b0, 1'b1, 17'h00005, 16'h1234, 1'b0, edges);
        chk("wr_latency",  32'(edges), 32'd4);
        chk("wr_addr1",    32'(snap_addr1), 32'h00005);
        chk("wr_data1",    32'(snap_data1), 32'h1234);
        chk("wr_we1_lo",   32'(we1_lo), 32'd2);
        tick();
        chk("wr_ack_drop", 32'(a_if.ack), 32'd0);
        chk("wr_busy_end", 32'(busy), 32'd0);
        chk("wr_en1_end",  32'(ram1EN), 32'd1);
        chk("wr_mem1",     32'(mem1[5]), 32'h1234);
        chk("wr_ram2_idle",32'(en2_lo + we2_lo + oe2_lo), 32'd0);
        chk("wr_a_acks",   32'(a_acks), 32'd1);
        chk("wr_last_b",   32'(last_b), 32'd0);

        // B reads ram2 word 5 (model holds 0xBEEF).
        mon_clear();
        run_xact(1'b1, 1'b0, 17'h10005, 16'h0000, 1'b0, edges);
        chk("rd_latency",  32'(edges), 32'd4);
        chk("rd_rdata",    32'(snap_rdata), 32'hBEEF);
        chk("rd_addr2",    32'(snap_addr2), 32'h00005);
        chk("rd_oe2_lo",   32'(oe2_lo), 32'd3);
        chk("rd_no_write", 32'(we1_lo + we2_lo + oe1_lo + en1_lo), 32'd0);
        tick();
        tick();
        tick();
        chk("rd_hold",     32'(b_if.rdata), 32'hBEEF);
        chk("rd_last_b",   32'(last_b), 32'd1);

        // Both request together after reset and hold: grants alternate A,B,A,B.
        do_reset();
        mon_clear();
        n_ack = 0;
        cyc   = 0;
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 17'h00010; a_if.wdata = 16'hA0A0;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 17'h10005; b_if.wdata = 16'h0000;
        for (int i = 0; i < 40 && n_ack < 4; i++) begin
            tick();
            cyc++;
            if (a_if.ack && n_ack < 4) begin
                ack_side[n_ack] = 0; ack_cyc[n_ack] = cyc; n_ack++;
            end
            if (b_if.ack && n_ack < 4) begin
                ack_side[n_ack] = 1; ack_cyc[n_ack] = cyc; n_ack++;
            end
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        chk("rr_ack_count", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_side%0d", i), 32'(ack_side[i]), 32'(i % 2));
            chk($sformatf("rr_cyc%0d", i),  32'(ack_cyc[i]),  32'(4 + 5 * i));
        end
        tick();
        tick();
        tick();
        chk("rr_viol",     32'(viol), 32'd0);
        chk("rr_b_rdata",  32'(b_if.rdata), 32'hBEEF);
        chk("rr_mem1",     32'(mem1[16]), 32'hA0A0);
        chk("rr_idle",     32'(busy), 32'd0);

        // Reset asserted during the ACCESS phase of a write.
        mon_clear();
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 17'h00020; a_if.wdata = 16'h5555;
        tick();
        tick();
        chk("ab_we1_low",  32'(ram1WE), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("ab_strobes",  32'({ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE}), 32'h3F);
        chk("ab_busy",     32'(busy), 32'd0);
        chk("ab_rdata",    32'(b_if.rdata), 32'd0);
        a_if.req = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("ab_no_ack",   32'(a_acks), 32'd0);
        chk("ab_busy_rel", 32'(busy), 32'd0);
        run_xact(1'b0, 1'b0, 17'h00005, 16'h0000, 1'b0, edges);
        chk("ab_next_lat", 32'(edges), 32'd4);
        chk("ab_next_rd",  32'(snap_rdata), 32'h1234);
        tick();

        // A changes its inputs mid-write; latched address and data must hold.
        mon_clear();
        run_xact(1'b0, 1'b1, 17'h00007, 16'h7777, 1'b1, edges);
        chk("mc_latency",  32'(edges), 32'd4);
        chk("mc_addr1",    32'(snap_addr1), 32'h00007);
        chk("mc_data1",    32'(snap_data1), 32'h7777);
        chk("mc_addr2",    32'(snap_addr2), 32'h00000);
        tick();
        tick();
        chk("mc_mem1",     32'(mem1[7]), 32'h7777);
        chk("mc_ram2",     32'(en2_lo), 32'd0);
        chk("mc_viol",     32'(viol), 32'd0);
        chk("mc_rdata",    32'(a_if.rdata), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
